// File: rtl/pla_term_counter.sv
// pla_term_counter
//   Monitors the four outputs of the PLA decoder. Each qualified sample
//   increments one saturating counter per asserted output. A dump request
//   snapshots all four counts, clears the live counters and streams the
//   snapshot out as four valid/ready beats (idx 0..3 = f1..f4).
//
// Optional feature:
//   PLA_ONEHOT_CHECK_EN  - when defined, a sticky flag reports any sample
//                          whose popcount is not exactly 1. When undefined,
//                          onehot_err is tied low.
//
// Parameters:
//   CNT_W       width of each occurrence counter and of dout_data (2..16)
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   f1..f4      decoder outputs, sampled when sample_en = 1
//   sample_en   qualifies f1..f4 as one sample
//   dump_start  single-cycle request to snapshot and stream the counts
//   dump_busy   high from the accepted dump_start until the last beat is taken
//   dout_valid  a count beat is presented
//   dout_ready  downstream accepts the beat
//   dout_idx    counter index of the current beat
//   dout_data   snapshotted count of the current beat
//   dout_last   high on the beat with dout_idx = 3
//   onehot_err  sticky non-one-hot sample flag
module pla_term_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             f1,
    input  logic             f2,
    input  logic             f3,
    input  logic             f4,
    input  logic             sample_en,
    input  logic             dump_start,
    output logic             dump_busy,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [1:0]       dout_idx,
    output logic [CNT_W-1:0] dout_data,
    output logic             dout_last,
    output logic             onehot_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic             hit);
        logic [CNT_W-1:0] res;
        if (hit && (cnt != CNT_MAX)) begin
            res = cnt + CNT_ONE;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    logic [3:0]       s_vec_r;
    logic             s_vld_r;
    logic [CNT_W-1:0] cnt_r  [0:3];
    logic [CNT_W-1:0] snap_r [0:3];
    state_t           state_r;
    logic             busy_r;
    logic             valid_r;
    logic [1:0]       idx_r;
    logic [CNT_W-1:0] data_r;
    logic             last_r;
    logic             dump_accept_s;
    logic [1:0]       idx_next_s;

    // Dump request is only honoured while the streamer is idle.
    always_comb begin
        dump_accept_s = 1'b0;
        idx_next_s    = idx_r + 2'd1;
        if (dump_start && (state_r == ST_IDLE)) begin
            dump_accept_s = 1'b1;
        end else begin
            dump_accept_s = 1'b0;
        end
    end

    // Input stage: capture one qualified sample, valid for exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_vec_r <= 4'b0000;
            s_vld_r <= 1'b0;
        end else if (sample_en) begin
            s_vec_r <= {f4, f3, f2, f1};
            s_vld_r <= 1'b1;
        end else begin
            s_vec_r <= s_vec_r;
            s_vld_r <= 1'b0;
        end
    end

    // Live counters and snapshot; on dump acceptance the live counters
    // restart from the in-flight sample only, which the snapshot excludes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                cnt_r[i]  <= CNT_ZERO;
                snap_r[i] <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (dump_accept_s) begin
                    snap_r[i] <= cnt_r[i];
                    cnt_r[i]  <= sat_inc(CNT_ZERO, s_vld_r & s_vec_r[i]);
                end else begin
                    snap_r[i] <= snap_r[i];
                    cnt_r[i]  <= sat_inc(cnt_r[i], s_vld_r & s_vec_r[i]);
                end
            end
        end
    end

    // Dump streamer: registered beat outputs, held while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            idx_r   <= 2'd0;
            data_r  <= CNT_ZERO;
            last_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (dump_accept_s) begin
                        // Beat 0 carries the value being snapshotted this edge.
                        state_r <= ST_SEND;
                        busy_r  <= 1'b1;
                        valid_r <= 1'b1;
                        idx_r   <= 2'd0;
                        data_r  <= cnt_r[0];
                        last_r  <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        valid_r <= 1'b0;
                        idx_r   <= 2'd0;
                        data_r  <= CNT_ZERO;
                        last_r  <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (dout_ready && (idx_r == 2'd3)) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        valid_r <= 1'b0;
                        idx_r   <= 2'd0;
                        data_r  <= CNT_ZERO;
                        last_r  <= 1'b0;
                    end else if (dout_ready) begin
                        state_r <= ST_SEND;
                        busy_r  <= 1'b1;
                        valid_r <= 1'b1;
                        idx_r   <= idx_next_s;
                        data_r  <= snap_r[idx_next_s];
                        last_r  <= (idx_next_s == 2'd3);
                    end else begin
                        state_r <= state_r;
                        busy_r  <= busy_r;
                        valid_r <= valid_r;
                        idx_r   <= idx_r;
                        data_r  <= data_r;
                        last_r  <= last_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    valid_r <= 1'b0;
                    idx_r   <= 2'd0;
                    data_r  <= CNT_ZERO;
                    last_r  <= 1'b0;
                end
            endcase
        end
    end

    assign dump_busy  = busy_r;
    assign dout_valid = valid_r;
    assign dout_idx   = idx_r;
    assign dout_data  = data_r;
    assign dout_last  = last_r;

`ifdef PLA_ONEHOT_CHECK_EN
    // Number of asserted decoder outputs in one sample.
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    logic err_r;

    // Sticky flag: any registered sample that is not exactly one-hot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (s_vld_r && (popcount4(s_vec_r) != 3'd1)) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign onehot_err = err_r;
`else
    assign onehot_err = 1'b0;
`endif

endmodule
